// File: rtl/eth_phy_10g_pkg.sv
// Shared definitions for the 10G PHY receive path: sync header codes and link-controller states.
// Latency: n/a (constants, types and an elaboration-time helper only).
// Backpressure: n/a.
package eth_phy_10g_pkg;

    // Sync header codes, shared with the block aligner
    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    typedef enum logic [2:0] {
        ST_WAIT_SERDES = 3'd0,
        ST_ALIGN_RST   = 3'd1,
        ST_WAIT_LOCK   = 3'd2,
        ST_LOCKED      = 3'd3,
        ST_HI_BER      = 3'd4,
        ST_SERDES_RST  = 3'd5
    } link_state_t;

    // Counter width for a counter that runs 0..limit-1; never narrower than one bit
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/eth_phy_10g_rx_ber_mon.sv
// High-BER monitor: free-running window counter plus saturating bad-sync-header counter.
// Latency: flags are combinational from registered counts and the current header; counts update each edge.
// Backpressure: none; one header per cycle is always accepted, clr resynchronises the window.
// Ports: clk/rst (sync, active-high), clr (sync clear of both counters), hdr/hdr_valid (aligned sync header),
//        thresh_hit (bad count incl. current header reached BER_THRESH), window_wrap (last cycle of window).
module eth_phy_10g_rx_ber_mon
    import eth_phy_10g_pkg::*;
#(
    parameter int HDR_WIDTH  = 2,
    parameter int BER_WINDOW = 19531,
    parameter int BER_THRESH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [HDR_WIDTH-1:0] hdr,
    input  logic                 hdr_valid,
    output logic                 thresh_hit,
    output logic                 window_wrap
);

    localparam int WIN_W = cnt_width(BER_WINDOW);
    localparam int BAD_W = $clog2(BER_THRESH + 1);
    localparam int SUM_W = BAD_W + 1;
    localparam logic [HDR_WIDTH-1:0] HDR_DATA = HDR_WIDTH'(SYNC_DATA);
    localparam logic [HDR_WIDTH-1:0] HDR_CTRL = HDR_WIDTH'(SYNC_CTRL);

    logic [WIN_W-1:0] win_cnt;
    logic [BAD_W-1:0] bad_cnt;
    logic [BAD_W-1:0] bad_next;
    logic [SUM_W-1:0] bad_sum;
    logic             bad;

    // Anything other than the two legal sync codes is an invalid header
    assign bad         = hdr_valid && (hdr != HDR_DATA) && (hdr != HDR_CTRL);
    assign bad_sum     = {1'b0, bad_cnt} + SUM_W'(bad);
    assign thresh_hit  = bad_sum >= SUM_W'(BER_THRESH);
    assign window_wrap = win_cnt == WIN_W'(BER_WINDOW - 1);
    // Saturate at the threshold: once reached, further bad headers change nothing
    assign bad_next    = thresh_hit ? BAD_W'(BER_THRESH) : bad_sum[BAD_W-1:0];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            win_cnt <= '0;
            bad_cnt <= '0;
        end else begin
            win_cnt <= window_wrap ? '0 : win_cnt + WIN_W'(1);
            // The header seen on the wrap cycle belongs to the closing window
            bad_cnt <= window_wrap ? '0 : bad_next;
        end
    end

endmodule

// File: rtl/eth_phy_10g_rx_link_ctrl.sv
// RX link sequencer: SERDES-ready gating, aligner reset hold, lock timeout/SERDES retry, high-BER tracking.
// Latency: inputs sampled at an edge are reflected on the registered outputs right after that edge.
// Backpressure: none; i_serdes_ready low in ALIGN_RST/WAIT_LOCK/LOCKED/HI_BER restarts bring-up.
// Ports: clk/rst (sync, active-high); i_serdes_ready, i_rx_block_lock, i_rx_hdr/i_rx_hdr_valid in;
//        o_aligner_rst, o_serdes_rx_reset, o_rx_high_ber, o_rx_status, o_retry_count (saturating) out.
module eth_phy_10g_rx_link_ctrl
    import eth_phy_10g_pkg::*;
#(
    parameter int HDR_WIDTH    = 2,
    parameter int RST_HOLD     = 16,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int BER_WINDOW   = 19531,
    parameter int BER_THRESH   = 16,
    parameter int RETRY_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_serdes_ready,
    input  logic                 i_rx_block_lock,
    input  logic [HDR_WIDTH-1:0] i_rx_hdr,
    input  logic                 i_rx_hdr_valid,
    output logic                 o_aligner_rst,
    output logic                 o_serdes_rx_reset,
    output logic                 o_rx_high_ber,
    output logic                 o_rx_status,
    output logic [RETRY_W-1:0]   o_retry_count
);

    localparam int HOLD_W = cnt_width(RST_HOLD);
    localparam int TMR_W  = cnt_width(LOCK_TIMEOUT);

    link_state_t        state, state_next;
    logic [HOLD_W-1:0]  hold_cnt, hold_cnt_next;
    logic [TMR_W-1:0]   lock_tmr, lock_tmr_next;
    logic [RETRY_W-1:0] retry_cnt, retry_next;
    logic               hold_done, tmr_done;
    logic               ber_clr, thresh_hit, window_wrap;

    assign hold_done     = hold_cnt == HOLD_W'(RST_HOLD - 1);
    assign tmr_done      = lock_tmr == TMR_W'(LOCK_TIMEOUT - 1);
    // Holding the monitor clear outside LOCKED/HI_BER starts a fresh window on lock
    assign ber_clr       = !(state inside {ST_LOCKED, ST_HI_BER});
    assign o_retry_count = retry_cnt;

    eth_phy_10g_rx_ber_mon #(
        .HDR_WIDTH  (HDR_WIDTH),
        .BER_WINDOW (BER_WINDOW),
        .BER_THRESH (BER_THRESH)
    ) u_ber_mon (
        .clk         (clk),
        .rst         (rst),
        .clr         (ber_clr),
        .hdr         (i_rx_hdr),
        .hdr_valid   (i_rx_hdr_valid),
        .thresh_hit  (thresh_hit),
        .window_wrap (window_wrap)
    );

    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        lock_tmr_next = lock_tmr;
        retry_next    = retry_cnt;
        case (state)
            ST_WAIT_SERDES: begin
                if (i_serdes_ready) begin
                    state_next    = ST_ALIGN_RST;
                    hold_cnt_next = '0;
                end
            end
            ST_ALIGN_RST: begin
                if (hold_done) begin
                    state_next    = ST_WAIT_LOCK;
                    lock_tmr_next = '0;
                end else begin
                    hold_cnt_next = hold_cnt + HOLD_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                // Lock seen on the timeout cycle still counts as a lock
                if (i_rx_block_lock) begin
                    state_next = ST_LOCKED;
                end else if (tmr_done) begin
                    state_next    = ST_SERDES_RST;
                    hold_cnt_next = '0;
                    retry_next    = (&retry_cnt) ? retry_cnt : retry_cnt + RETRY_W'(1);
                end else begin
                    lock_tmr_next = lock_tmr + TMR_W'(1);
                end
            end
            ST_LOCKED: begin
                if (!i_rx_block_lock) begin
                    state_next    = ST_WAIT_LOCK;
                    lock_tmr_next = '0;
                end else if (thresh_hit) begin
                    state_next = ST_HI_BER;
                end else if (window_wrap) begin
                    // A full clean window means the link recovered; forget past retries
                    retry_next = '0;
                end
            end
            ST_HI_BER: begin
                if (!i_rx_block_lock) begin
                    state_next    = ST_WAIT_LOCK;
                    lock_tmr_next = '0;
                end else if (window_wrap && !thresh_hit) begin
                    state_next = ST_LOCKED;
                end
            end
            ST_SERDES_RST: begin
                if (hold_done) begin
                    state_next = ST_WAIT_SERDES;
                end else begin
                    hold_cnt_next = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                state_next = ST_WAIT_SERDES;
            end
        endcase
        // Losing SERDES ready outranks everything and is not a retry
        if (!i_serdes_ready && (state inside {ST_ALIGN_RST, ST_WAIT_LOCK, ST_LOCKED, ST_HI_BER})) begin
            state_next = ST_WAIT_SERDES;
            retry_next = retry_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_WAIT_SERDES;
            hold_cnt          <= '0;
            lock_tmr          <= '0;
            retry_cnt         <= '0;
            o_aligner_rst     <= 1'b1;
            o_serdes_rx_reset <= 1'b0;
            o_rx_high_ber     <= 1'b0;
            o_rx_status       <= 1'b0;
        end else begin
            state             <= state_next;
            hold_cnt          <= hold_cnt_next;
            lock_tmr          <= lock_tmr_next;
            retry_cnt         <= retry_next;
            // Outputs decoded from the next state so they land with the state change
            o_aligner_rst     <= state_next inside {ST_WAIT_SERDES, ST_ALIGN_RST, ST_SERDES_RST};
            o_serdes_rx_reset <= state_next == ST_SERDES_RST;
            o_rx_high_ber     <= state_next == ST_HI_BER;
            o_rx_status       <= state_next == ST_LOCKED;
        end
    end

endmodule

// File: tb/tb_eth_phy_10g_rx_link_ctrl.sv
// Randomized/directed bench for eth_phy_10g_rx_link_ctrl with a phase/age reference model and scoreboard.
// Latency: expected outputs for each input cycle are queued and compared 1 time unit after the next edge.
// Backpressure: n/a.
module tb_eth_phy_10g_rx_link_ctrl;

    localparam int HOLD  = 4;
    localparam int TO    = 50;
    localparam int BW    = 100;
    localparam int TH    = 4;
    localparam int RMAX  = 15;

    logic       clk;
    logic       rst;
    logic       i_serdes_ready;
    logic       i_rx_block_lock;
    logic [1:0] i_rx_hdr;
    logic       i_rx_hdr_valid;
    logic       o_aligner_rst;
    logic       o_serdes_rx_reset;
    logic       o_rx_high_ber;
    logic       o_rx_status;
    logic [3:0] o_retry_count;

    eth_phy_10g_rx_link_ctrl #(
        .HDR_WIDTH    (2),
        .RST_HOLD     (HOLD),
        .LOCK_TIMEOUT (TO),
        .BER_WINDOW   (BW),
        .BER_THRESH   (TH),
        .RETRY_W      (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_serdes_ready    (i_serdes_ready),
        .i_rx_block_lock   (i_rx_block_lock),
        .i_rx_hdr          (i_rx_hdr),
        .i_rx_hdr_valid    (i_rx_hdr_valid),
        .o_aligner_rst     (o_aligner_rst),
        .o_serdes_rx_reset (o_serdes_rx_reset),
        .o_rx_high_ber     (o_rx_high_ber),
        .o_rx_status       (o_rx_status),
        .o_retry_count     (o_retry_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    // ---------------- reference model ----------------
    // Link phase plus the number of cycles already spent in it; BER window position
    // is derived from the cycle on which lock was first entered.
    typedef enum {M_DOWN, M_ARST, M_SEEK, M_UP, M_DEGRADED, M_SRST} mphase_t;
    mphase_t ph    = M_DOWN;
    int      age   = 0;
    int      mcyc  = 0;
    int      t0    = 0;
    int      nbad  = 0;
    int      retry = 0;

    function automatic int win_pos();
        return (mcyc - t0) % BW;
    endfunction

    task automatic model_step();
        mphase_t nx;
        int      b;
        bit      wrap;
        bit      badh;
        nx   = ph;
        badh = i_rx_hdr_valid && !(i_rx_hdr == 2'b01 || i_rx_hdr == 2'b10);
        wrap = (win_pos() == BW - 1);
        b    = nbad + int'(badh);
        if (rst) begin
            nx    = M_DOWN;
            retry = 0;
            nbad  = 0;
        end else if (!i_serdes_ready && (ph inside {M_ARST, M_SEEK, M_UP, M_DEGRADED})) begin
            nx = M_DOWN;
        end else begin
            case (ph)
                M_DOWN: if (i_serdes_ready) nx = M_ARST;
                M_ARST: if (age == HOLD - 1) nx = M_SEEK;
                M_SEEK: begin
                    if (i_rx_block_lock) begin
                        nx   = M_UP;
                        t0   = mcyc + 1;
                        nbad = 0;
                    end else if (age == TO - 1) begin
                        nx = M_SRST;
                        if (retry < RMAX) retry++;
                    end
                end
                M_UP: begin
                    if (!i_rx_block_lock) nx = M_SEEK;
                    else begin
                        if (b >= TH) nx = M_DEGRADED;
                        else if (wrap) retry = 0;
                        nbad = wrap ? 0 : b;
                    end
                end
                M_DEGRADED: begin
                    if (!i_rx_block_lock) nx = M_SEEK;
                    else begin
                        if (wrap && b < TH) nx = M_UP;
                        nbad = wrap ? 0 : b;
                    end
                end
                M_SRST: if (age == HOLD - 1) nx = M_DOWN;
                default: nx = M_DOWN;
            endcase
        end
        age = (nx == ph && !rst) ? age + 1 : 0;
        ph  = nx;
        mcyc++;
        exp_q.push_back({(ph inside {M_DOWN, M_ARST, M_SRST}), (ph == M_SRST),
                         (ph == M_DEGRADED), (ph == M_UP), 4'(retry)});
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [7:0] want;
        logic [7:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got  = {o_aligner_rst, o_serdes_rx_reset, o_rx_high_ber, o_rx_status, o_retry_count};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL outputs t=%0t got aln=%b srst=%b hber=%b status=%b retry=%0d want aln=%b srst=%b hber=%b status=%b retry=%0d",
                             $time, got[7], got[6], got[5], got[4], got[3:0],
                             want[7], want[6], want[5], want[4], want[3:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [1:0] good_hdr();
        return ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] bad_hdr();
        return ($urandom_range(0, 1) == 1) ? 2'b00 : 2'b11;
    endfunction

    // Called at a falling edge: apply inputs, queue the expected response, move to next falling edge
    task automatic drive(input bit r, input bit rdy, input bit lk, input logic [1:0] h, input bit v);
        rst             = r;
        i_serdes_ready  = rdy;
        i_rx_block_lock = lk;
        i_rx_hdr        = h;
        i_rx_hdr_valid  = v;
        model_step();
        @(negedge clk);
    endtask

    task automatic good(input int n);
        for (int i = 0; i < n; i++) drive(0, 1, 1, good_hdr(), 1);
    endtask

    task automatic until_phase(input mphase_t p, input bit lk, input int budget);
        int n;
        n = 0;
        while (ph != p && n < budget) begin
            drive(0, 1, lk, good_hdr(), 1);
            n++;
        end
        checks++;
        if (ph != p) begin
            errors++;
            $display("FAIL phase_wait got=%s want=%s", ph.name(), p.name());
        end
    endtask

    task automatic until_pos(input int p);
        int n;
        n = 0;
        while (!((ph inside {M_UP, M_DEGRADED}) && win_pos() == p) && n < 3 * BW) begin
            drive(0, 1, 1, good_hdr(), 1);
            n++;
        end
        checks++;
        if (!((ph inside {M_UP, M_DEGRADED}) && win_pos() == p)) begin
            errors++;
            $display("FAIL window_wait got_phase=%s want_pos=%0d", ph.name(), p);
        end
    endtask

    task automatic bring_up(input int lock_delay);
        until_phase(M_SEEK, 0, 20);
        for (int i = 0; i < lock_delay; i++) drive(0, 1, 0, good_hdr(), 1);
        good(10);
    endtask

    initial begin
        logic       r, rdy, lk, v;
        logic [1:0] h;
        int         n;
        rst = 1'b1; i_serdes_ready = 1'b0; i_rx_block_lock = 1'b0;
        i_rx_hdr = 2'b01; i_rx_hdr_valid = 1'b0;
        @(negedge clk);

        // Reset, then ready arrives at cycle 10 and lock 20 cycles after aligner reset falls
        repeat (3) drive(1, 0, 0, 2'b01, 0);
        repeat (10) drive(0, 0, 0, 2'b01, 0);
        bring_up(20);
        good(200);

        // High BER: 4 bad in one window, stays through the wrap, 3 bad next window recovers
        until_pos(0);
        for (int i = 0; i < TH; i++) begin
            drive(0, 1, 1, bad_hdr(), 1);
            good(5);
        end
        until_pos(0);
        for (int i = 0; i < TH - 1; i++) begin
            drive(0, 1, 1, bad_hdr(), 1);
            good(5);
        end
        until_pos(0);
        good(20);

        // 4th bad header exactly on the wrap cycle, then ready drops while in HI_BER
        until_pos(0);
        for (int i = 0; i < TH - 1; i++) drive(0, 1, 1, bad_hdr(), 1);
        until_pos(BW - 1);
        drive(0, 1, 1, bad_hdr(), 1);
        good(3);
        drive(0, 0, 1, good_hdr(), 1);
        repeat (2) drive(0, 0, 1, good_hdr(), 1);
        bring_up(3);

        // Lock drop coincident with the 4th bad header
        until_pos(0);
        for (int i = 0; i < TH - 1; i++) drive(0, 1, 1, bad_hdr(), 1);
        drive(0, 1, 0, bad_hdr(), 1);

        // Repeated lock timeouts up to and past retry saturation
        n = 0;
        while (retry < RMAX && n < 2000) begin
            drive(0, 1, 0, good_hdr(), 1);
            n++;
        end
        repeat (130) drive(0, 1, 0, good_hdr(), 1);

        // Reset in the middle of SERDES_RST, then a normal bring-up and a clean window
        until_phase(M_SRST, 0, 200);
        drive(0, 1, 0, good_hdr(), 1);
        drive(1, 1, 0, good_hdr(), 1);
        bring_up(5);
        good(120);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            r   = ($urandom_range(0, 499) == 0);
            rdy = ($urandom_range(0, 199) != 0);
            lk  = ($urandom_range(0, 149) != 0);
            h   = ($urandom_range(0, 24) == 0) ? bad_hdr() : good_hdr();
            v   = ($urandom_range(0, 7) != 0);
            drive(r, rdy, lk, h, v);
        end

        drive(0, 1, 1, good_hdr(), 1);
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
